// File: rtl/sysbus_interconnect_if.sv
// rtl/sysbus_interconnect_if.sv - master-side and slave-side bus bundles for the system interconnect
interface mbus_if #(
    parameter int DW = 32
);
    logic          m_en;
    logic          m_rdwr;
    logic [31:0]   m_addr;
    logic [DW-1:0] m_wr_data;
    logic [DW/8-1:0] m_mask;
    logic          m_busy;
    logic          m_rd_valid;
    logic [DW-1:0] m_rd_data;
    logic          m_err;

    modport master (
        output m_en, m_rdwr, m_addr, m_wr_data, m_mask,
        input  m_busy, m_rd_valid, m_rd_data, m_err
    );
    modport slave (
        input  m_en, m_rdwr, m_addr, m_wr_data, m_mask,
        output m_busy, m_rd_valid, m_rd_data, m_err
    );
endinterface

interface sbus_if #(
    parameter int N_SLV = 3,
    parameter int DW    = 32
);
    logic [N_SLV-1:0]    s_en;
    logic                s_rdwr;
    logic [31:0]         s_addr;
    logic [DW-1:0]       s_wr_data;
    logic [DW/8-1:0]     s_mask;
    logic [N_SLV*DW-1:0] s_rd_data;
    logic [N_SLV-1:0]    s_rd_valid;

    modport master (
        output s_en, s_rdwr, s_addr, s_wr_data, s_mask,
        input  s_rd_data, s_rd_valid
    );
    modport slave (
        input  s_en, s_rdwr, s_addr, s_wr_data, s_mask,
        output s_rd_data, s_rd_valid
    );
endinterface

// File: rtl/sysbus_interconnect.sv
// rtl/sysbus_interconnect.sv - single-master N-slave bus decoder with one outstanding read
module sysbus_interconnect #(
    parameter int N_SLV  = 3,
    parameter int SEL_HI = 31,
    parameter int SEL_LO = 28,
    parameter logic [N_SLV*(SEL_HI-SEL_LO+1)-1:0] SLV_TAG = {4'h8, 4'h9, 4'h0},
    parameter int TIMEOUT = 15,
    parameter int DW      = 32
) (
    input  logic        clk,
    input  logic        rst,
    mbus_if.slave       m,
    sbus_if.master      s,
    output logic [15:0] err_count
);
    localparam int TW  = SEL_HI - SEL_LO + 1;
    localparam int SW  = (N_SLV > 1) ? $clog2(N_SLV) : 1;
    localparam int TMW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state;
    logic            busy_q;
    logic            rd_valid_q;
    logic            err_q;
    logic [DW-1:0]   rd_data_q;
    logic [15:0]     err_cnt_q;
    logic [SW-1:0]   sel_q;
    logic [TMW-1:0]  timer;
    logic [SW-1:0]   sel;
    logic            any_hit;
    logic            accept;

    // Descending scan so the lowest matching index is the last one written.
    always_comb begin
        any_hit = 1'b0;
        sel     = '0;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if (m.m_addr[SEL_HI:SEL_LO] == SLV_TAG[i*TW +: TW]) begin
                any_hit = 1'b1;
                sel     = SW'(i);
            end
        end
    end

    assign accept      = m.m_en & ~busy_q & any_hit;
    assign s.s_en      = accept ? (N_SLV'(1) << sel) : '0;
    assign s.s_rdwr    = m.m_rdwr;
    assign s.s_addr    = m.m_addr & 32'hFFFF_FFFC;
    assign s.s_wr_data = m.m_wr_data;
    assign s.s_mask    = m.m_mask;

    assign m.m_busy     = busy_q;
    assign m.m_rd_valid = rd_valid_q;
    assign m.m_rd_data  = rd_data_q;
    assign m.m_err      = err_q;
    assign err_count    = err_cnt_q;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            busy_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
            rd_data_q  <= '0;
            err_cnt_q  <= '0;
            sel_q      <= '0;
            timer      <= '0;
        end else begin
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
            case (state)
                IDLE: begin
                    if (m.m_en && !any_hit) begin
                        // Unmapped: writes only raise the error, reads also return zero data.
                        state      <= RESP;
                        busy_q     <= 1'b1;
                        err_q      <= 1'b1;
                        rd_valid_q <= ~m.m_rdwr;
                        if (!m.m_rdwr) rd_data_q <= '0;
                        err_cnt_q  <= sat_inc(err_cnt_q);
                    end else if (m.m_en && !m.m_rdwr) begin
                        state  <= WAIT;
                        busy_q <= 1'b1;
                        sel_q  <= sel;
                        timer  <= '0;
                    end
                end
                WAIT: begin
                    if (s.s_rd_valid[sel_q]) begin
                        state      <= RESP;
                        rd_valid_q <= 1'b1;
                        rd_data_q  <= s.s_rd_data[sel_q*DW +: DW];
                    end else if (timer == TMW'(TIMEOUT - 1)) begin
                        state      <= RESP;
                        rd_valid_q <= 1'b1;
                        err_q      <= 1'b1;
                        rd_data_q  <= '0;
                        err_cnt_q  <= sat_inc(err_cnt_q);
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RESP: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end
endmodule
